// File: rtl/timebase_ctl.sv
// Purpose: system timebase - refresh cadence from E, QoS hold channels gating MCKE, C8M health and startup sequencing.
// Latency: all outputs registered (QoSAct is combinational from the hold counters); RefReq/RefUrg/RefTick 1 cycle after EFall.
// Backpressure: none; free-running, inputs sampled every CLK.
//
// Ports: CLK/RST clock and sync reset; C8M/E async clocks (synchronised here);
//   nRESin/nIPL2/nAS/ASrf/BACT/QoSCS board and bus inputs;
//   RefReq/RefUrg/RefTick refresh timing; QoSAct/QoSEN/MCKE clock gating;
//   nRESout/AoutOE/nBR_IOB startup sequencing to the PDS.
module timebase_ctl #(
  parameter int REF_PERIOD = 11,
  parameter int REF_URG    = 9,
  parameter int QOS_CH     = 2,
  parameter int QOS_W      = 4,
  parameter int LT_W       = 12,
  parameter int HOLD_TICKS = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              C8M,
  input  logic              E,
  input  logic              nRESin,
  input  logic              nIPL2,
  input  logic              nAS,
  input  logic              ASrf,
  input  logic              BACT,
  input  logic [QOS_CH-1:0] QoSCS,
  output logic              RefReq,
  output logic              RefUrg,
  output logic              RefTick,
  output logic [QOS_CH-1:0] QoSAct,
  output logic              QoSEN,
  output logic              MCKE,
  output logic              nRESout,
  output logic              AoutOE,
  output logic              nBR_IOB
);

  localparam int TW = $clog2(REF_PERIOD);

  typedef enum logic [1:0] {ST_HOLD = 2'd0, ST_ARB = 2'd1, ST_RUN = 2'd2} state_e;

  // Synchronisers: index 0 is the newest sample.
  logic [1:0] e_r_q;
  logic [3:0] c8m_r_q;
  logic       e_fall, c8m_fall;

  logic [TW-1:0]   timer_q, timer_d;
  logic            timer_wrap;
  logic            ref_req_q, ref_urg_q, ref_tick_q;

  logic [QOS_CH-1:0] tr_q, tr_d;
  logic [QOS_W-1:0]  qos_cnt_q [QOS_CH];
  logic [QOS_W-1:0]  qos_cnt_d [QOS_CH];
  logic              qos_en_q, mcke_q;

  logic [LT_W-1:0] lt_q;
  logic            ltick_q;
  logic            npor_q;

  state_e     state_q, state_d;
  logic [2:0] stage_q, stage_d;
  logic       aoe_q, aoe_d, nres_q, nres_d, nbr_q, nbr_d;

  assign e_fall   = e_r_q[1] & ~e_r_q[0];
  assign c8m_fall = c8m_r_q[1] & ~c8m_r_q[0];

  // Refresh timer and QoS next-state
  always_comb begin
    timer_wrap = (timer_q == TW'(REF_PERIOD - 1));
    timer_d    = timer_q;
    if (e_fall) timer_d = timer_wrap ? '0 : timer_q + TW'(1);

    tr_d    = QoSCS & {QOS_CH{BACT}};
    // Board reset keeps channel 0 holding the 68k clock gate open.
    tr_d[0] = tr_d[0] | ~nRESin;

    for (int i = 0; i < QOS_CH; i++) begin
      qos_cnt_d[i] = qos_cnt_q[i];
      // Reload has priority over a decrement on the same cycle.
      if (tr_q[i])
        qos_cnt_d[i] = '1;
      else if ((qos_cnt_q[i] != '0) && ref_tick_q)
        qos_cnt_d[i] = qos_cnt_q[i] - QOS_W'(1);
      QoSAct[i] = (qos_cnt_q[i] != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      e_r_q      <= '0;
      c8m_r_q    <= '0;
      timer_q    <= '0;
      ref_req_q  <= 1'b0;
      ref_urg_q  <= 1'b0;
      ref_tick_q <= 1'b0;
      tr_q       <= '0;
      for (int i = 0; i < QOS_CH; i++) qos_cnt_q[i] <= '0;
      qos_en_q   <= 1'b0;
      mcke_q     <= 1'b1;
      lt_q       <= '0;
      ltick_q    <= 1'b0;
      npor_q     <= 1'b0;
    end else begin
      e_r_q   <= {e_r_q[0], E};
      c8m_r_q <= {c8m_r_q[2:0], C8M};
      timer_q <= timer_d;
      if (e_fall) begin
        ref_req_q <= (timer_d != '0);
        ref_urg_q <= (timer_d >= TW'(REF_URG));
      end
      ref_tick_q <= e_fall & timer_wrap;
      tr_q       <= tr_d;
      for (int i = 0; i < QOS_CH; i++) qos_cnt_q[i] <= qos_cnt_d[i];
      // QoSEN only follows the channels between bus cycles.
      if (!BACT) qos_en_q <= |QoSAct;
      mcke_q <= ~nAS | ASrf | ~qos_en_q | c8m_fall;
      if (ref_tick_q) lt_q <= lt_q + LT_W'(1);
      ltick_q <= ref_tick_q & (&lt_q);
      // A C8M stuck for four samples drops power-on-good; a rising edge restores it.
      if ((c8m_r_q == 4'b0000) || (c8m_r_q == 4'b1111))
        npor_q <= 1'b0;
      else if (c8m_r_q[1:0] == 2'b01)
        npor_q <= 1'b1;
    end
  end

  // Startup FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_HOLD;
      stage_q <= '0;
      aoe_q   <= 1'b0;
      nres_q  <= 1'b0;
      nbr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      aoe_q   <= aoe_d;
      nres_q  <= nres_d;
      nbr_q   <= nbr_d;
    end
  end

  // Startup FSM: next state
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    if (!npor_q) begin
      state_d = ST_HOLD;
      stage_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: if (ltick_q) begin
          if (stage_q == 3'(HOLD_TICKS - 1)) begin
            state_d = ST_ARB;
            stage_d = '0;
          end else begin
            stage_d = stage_q + 3'd1;
          end
        end
        ST_ARB:  if (ltick_q && nIPL2) state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_HOLD;
      endcase
    end
  end

  // Startup FSM: outputs, from the current state so RUN rules start the cycle after entry
  always_comb begin
    aoe_d  = 1'b0;
    nres_d = 1'b0;
    nbr_d  = 1'b0;
    if (npor_q) begin
      case (state_q)
        ST_ARB: nbr_d = nbr_q | ~nIPL2;
        ST_RUN: begin
          aoe_d  = ~nbr_q;
          nres_d = nres_q | ltick_q;
          nbr_d  = nbr_q;
        end
        default: ;
      endcase
    end
  end

  assign RefReq  = ref_req_q;
  assign RefUrg  = ref_urg_q;
  assign RefTick = ref_tick_q;
  assign QoSEN   = qos_en_q;
  assign MCKE    = mcke_q;
  assign nRESout = nres_q;
  assign AoutOE  = aoe_q;
  assign nBR_IOB = nbr_q;

endmodule

// File: tb/tb_timebase_ctl.sv
module tb_timebase_ctl;

  localparam int REF_PERIOD = 11;
  localparam int REF_URG    = 9;
  localparam int QOS_CH     = 2;
  localparam int QOS_W      = 4;
  localparam int LT_W       = 2;
  localparam int HOLD_TICKS = 2;
  localparam int QOS_MAX    = (1 << QOS_W) - 1;
  localparam int LT_MOD     = 1 << LT_W;
  localparam int S_HOLD = 0, S_ARB = 1, S_RUN = 2;

  logic clk;
  logic rst, c8m, e, nresin, nipl2, nas, asrf, bact;
  logic [1:0] qoscs;
  logic ref_req, ref_urg, ref_tick, qos_en, mcke, nres_out, aout_oe, nbr_iob;
  logic [1:0] qos_act;

  timebase_ctl #(
    .REF_PERIOD(REF_PERIOD), .REF_URG(REF_URG), .QOS_CH(QOS_CH),
    .QOS_W(QOS_W), .LT_W(LT_W), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .CLK(clk), .RST(rst), .C8M(c8m), .E(e), .nRESin(nresin), .nIPL2(nipl2),
    .nAS(nas), .ASrf(asrf), .BACT(bact), .QoSCS(qoscs),
    .RefReq(ref_req), .RefUrg(ref_urg), .RefTick(ref_tick), .QoSAct(qos_act),
    .QoSEN(qos_en), .MCKE(mcke), .nRESout(nres_out), .AoutOE(aout_oe), .nBR_IOB(nbr_iob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected output vector: {RefReq,RefUrg,RefTick,QoSAct[1:0],QoSEN,MCKE,nRESout,AoutOE,nBR_IOB}
  logic [9:0] exp_q[$];

  // ---------------- reference model ----------------
  bit [1:0] e_hist;       // [0] newest sample
  bit [3:0] c_hist;
  int  m_timer, m_lt, m_stage, m_state;
  int  m_cnt [2];
  bit [1:0] m_tr;
  bit  m_req, m_urg, m_tick, m_ltick, m_en, m_mcke, m_npor, m_nres, m_aoe, m_nbr;
  bit  efall, cfall, any_act, o_tick, o_ltick, o_npor, o_nbr, o_en;
  int  o_state;

  always @(posedge clk) begin
    if (rst) begin
      e_hist = '0; c_hist = '0;
      m_timer = 0; m_lt = 0; m_stage = 0; m_state = S_HOLD;
      m_cnt[0] = 0; m_cnt[1] = 0; m_tr = '0;
      m_req = 0; m_urg = 0; m_tick = 0; m_ltick = 0; m_en = 0; m_mcke = 1;
      m_npor = 0; m_nres = 0; m_aoe = 0; m_nbr = 0;
    end else begin
      efall   = e_hist[1] && !e_hist[0];
      cfall   = c_hist[1] && !c_hist[0];
      any_act = (m_cnt[0] != 0) || (m_cnt[1] != 0);
      o_tick = m_tick; o_ltick = m_ltick; o_npor = m_npor;
      o_state = m_state; o_nbr = m_nbr; o_en = m_en;

      m_tick = efall && (m_timer == REF_PERIOD - 1);
      if (efall) begin
        m_timer = (m_timer + 1) % REF_PERIOD;
        m_req = (m_timer != 0);
        m_urg = (m_timer >= REF_URG);
      end

      for (int i = 0; i < 2; i++) begin
        if (m_tr[i]) m_cnt[i] = QOS_MAX;
        else if (m_cnt[i] > 0 && o_tick) m_cnt[i] = m_cnt[i] - 1;
      end
      m_tr[0] = (bact && qoscs[0]) || !nresin;
      m_tr[1] = bact && qoscs[1];

      if (!bact) m_en = any_act;
      m_mcke = !nas || asrf || !o_en || cfall;

      m_ltick = o_tick && (m_lt == LT_MOD - 1);
      if (o_tick) m_lt = (m_lt + 1) % LT_MOD;

      if (c_hist == 4'h0 || c_hist == 4'hF) m_npor = 0;
      else if (c_hist[1:0] == 2'b01) m_npor = 1;

      if (!o_npor) begin
        m_state = S_HOLD; m_stage = 0;
      end else if (o_state == S_HOLD && o_ltick) begin
        m_stage = m_stage + 1;
        if (m_stage == HOLD_TICKS) begin m_state = S_ARB; m_stage = 0; end
      end else if (o_state == S_ARB && o_ltick && nipl2) begin
        m_state = S_RUN;
      end

      if (!o_npor || o_state == S_HOLD) begin
        m_aoe = 0; m_nres = 0; m_nbr = 0;
      end else if (o_state == S_ARB) begin
        m_aoe = 0; m_nres = 0; m_nbr = o_nbr || !nipl2;
      end else begin
        m_aoe = !o_nbr; m_nres = m_nres || o_ltick;
      end

      e_hist = {e_hist[0], e};
      c_hist = {c_hist[2:0], c8m};
    end
    exp_q.push_back({m_req, m_urg, m_tick, m_cnt[1] != 0, m_cnt[0] != 0,
                     m_en, m_mcke, m_nres, m_aoe, m_nbr});
  end

  // ---------------- monitor ----------------
  logic [9:0] got, want;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {ref_req, ref_urg, ref_tick, qos_act, qos_en, mcke, nres_out, aout_oe, nbr_iob};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL outputs t=%0t got=%b want=%b (req,urg,tick,act1,act0,en,mcke,nres,aoe,nbr)",
                 $time, got, want);
      end
    end
  end

  // ---------------- stimulus ----------------
  int  e_cnt = 0;
  bit  c_ph = 0;
  bit  c8m_stuck = 0;
  bit  qos_rand = 1;
  bit  nipl2_lvl = 1;

  task automatic step();
    @(posedge clk);
    #1;
    if (e_cnt == 4) begin e_cnt = 0; e = ~e; end else e_cnt++;
    if (c8m_stuck) c8m = 1'b1;
    else begin
      if (c_ph) c8m = ~c8m;
      c_ph = ~c_ph;
    end
    bact   = ($urandom_range(0, 2) == 0);
    qoscs  = (qos_rand && $urandom_range(0, 299) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    nas    = 1'($urandom_range(0, 1));
    asrf   = ($urandom_range(0, 3) == 0);
    nresin = !(qos_rand && $urandom_range(0, 999) == 0);
    nipl2  = nipl2_lvl;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    rst = 1; e = 0; c8m = 0; nresin = 1; nipl2 = 1; nas = 1; asrf = 0; bact = 0; qoscs = 0;
    run(3);
    rst = 0;

    // Random traffic through startup into RUN
    run(3000);

    // Channel 1 trigger coinciding with a RefTick while its counter is 3
    qos_rand = 0;
    step(); bact = 1; qoscs = 2'b10;
    n = 0;
    while (m_cnt[1] != 3 && n < 2500) begin step(); n++; end
    checks++;
    if (m_cnt[1] != 3) begin errors++; $display("FAIL wait_cnt3 count=%0d want=3", m_cnt[1]); end
    n = 0;
    while (!(e_hist[1] && !e_hist[0] && m_timer == REF_PERIOD - 1) && n < 300) begin step(); n++; end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL wait_wrap cycles=%0d limit=300", n); end
    bact = 1; qoscs = 2'b10;
    run(2200);

    // C8M stuck high: power-on-good drops, back to HOLD; then ARB with NMI held
    c8m_stuck = 1; nipl2_lvl = 0;
    run(8);
    c8m_stuck = 0;
    run(1500);
    nipl2_lvl = 1;
    run(2000);

    // Reset in the middle of a QoS hold
    step(); bact = 1; qoscs = 2'b01;
    run(3);
    rst = 1;
    run(2);
    rst = 0;
    run(300);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timebase_ctl.md
Name: timebase_ctl

Overview:
Parametrised system timebase for the accelerator CPLD. Derives the DRAM refresh request/urgency cadence from the E clock and runs N independent QoS hold channels that gate the 68k clock. Also checks C8M health for power-on reset and sequences PDS bus request and reset release. It generalises the fixed-width single-path counter block: refresh period, urgency point, QoS channel count, hold length, long-timer width and reset-hold length are all parameters.

Parameters:
REF_PERIOD, 11, number of refresh timer states per E-tick cycle; Timer counts 0..REF_PERIOD-1 (min 3).
REF_URG, 9, first Timer value at which RefUrg is asserted (1 < REF_URG < REF_PERIOD).
QOS_CH, 2, number of QoS trigger channels (1..8).
QOS_W, 4, width of each QoS hold counter; reload value is 2^QOS_W-1.
LT_W, 12, long timer width; one LTick per 2^LT_W TimerTicks.
HOLD_TICKS, 2, LTicks spent in HOLD before ARB (1..7).

Ports:
CLK  in  1  FSB clock; all logic on posedge.
RST  in  1  synchronous active-high reset.
C8M  in  1  asynchronous 8 MHz clock.
E  in  1  asynchronous 68k E clock.
nRESin  in  1  board reset, active low; forces QoS channel 0 reload.
nIPL2  in  1  NMI button level, active low.
nAS  in  1  68k address strobe.
ASrf  in  1  address-strobe-related FSB qualifier.
BACT  in  1  bus cycle active.
QoSCS  in  QOS_CH  per-channel QoS trigger selects.
RefReq  out  1  refresh requested.
RefUrg  out  1  refresh urgent.
RefTick  out  1  one-cycle pulse at refresh-period wrap.
QoSAct  out  QOS_CH  channel i hold counter nonzero.
QoSEN  out  1  QoS enable.
MCKE  out  1  68k clock enable.
nRESout  out  1  system reset out, active low.
AoutOE  out  1  PDS address/control output enable.
nBR_IOB  out  1  PDS bus request, active low.

Behaviour:
- Sync: E through 2 flops, EFall = Er[1]&!Er[0]; C8M through 4 flops, C8MFall = C8Mr[1]&!C8Mr[0].
- Refresh: on EFall, Timer wraps to 0 at REF_PERIOD-1, else increments. On the same edge RefReq <= (next Timer != 0) and RefUrg <= (next Timer >= REF_URG). Both outputs change 1 cycle after EFall. RefTick is registered: 1 cycle after the EFall on which Timer==REF_PERIOD-1.
- QoS channel i: trigger register Tr[i] <= BACT&QoSCS[i], with channel 0 also set when !nRESin. Per CLK: if Tr[i], reload all-ones; else if counter==0, hold 0; else if RefTick, decrement. Reload wins over a simultaneous RefTick. QoSAct[i] = counter!=0, combinational from the register.
- QoSEN: registered; updates to OR(QoSAct) only on cycles with BACT=0, otherwise holds.
- MCKE: registered on posedge CLK. 1 if nAS=0, else ASrf | !QoSEN | C8MFall.
- Long timer: LT_W-bit, increments on RefTick and wraps. LTick is a registered pulse on RefTick with LT all-ones.
- nPOR: cleared when C8Mr==0000 or 1111 (stuck C8M); set when C8Mr[1:0]==01; otherwise held.
- Startup FSM: HOLD -> ARB -> RUN.
  - HOLD: a 3-bit stage counter counts LTicks; go to ARB after HOLD_TICKS LTicks.
  - ARB: go to RUN on LTick with nIPL2=1.
  - RUN: absorbing.
  - nPOR=0 forces HOLD with the stage counter cleared, from any state, including mid-RUN.
- Outputs by state, all registered:
  - HOLD: AoutOE=0, nRESout=0, nBR_IOB=0.
  - ARB: AoutOE=0, nRESout=0; nBR_IOB set to 1 if nIPL2=0 (sticky until back in HOLD).
  - RUN: AoutOE<=!nBR_IOB; nRESout set to 1 on LTick (sticky).
- RST values: Timer, QoS counters, Tr, LT and stage counter cleared; Er/C8Mr cleared; nPOR=0; FSM=HOLD. RefReq=0, RefUrg=0, RefTick=0, QoSAct=0, QoSEN=0, MCKE=1, nRESout=0, AoutOE=0, nBR_IOB=0. RST overrides all other inputs.

Test Plan:
- Defaults, 22 E periods, C8M toggling: RefReq is 0 for exactly 1 E period per 11, RefUrg is 1 for Timer 9,10; RefTick pulses twice, 1 CLK wide.
- BACT=1, QoSCS=01 for 1 cycle: QoSAct=01 within 2 cycles; QoSEN rises only after BACT=0; counter reaches 0 after 15 RefTicks; QoSEN drops on the next BACT=0 cycle.
- QoSCS[1] trigger on the same cycle as RefTick with the counter at 3: counter reloads to 15, not 2.
- nAS=1, QoSEN=1, ASrf=0: MCKE=1 only in cycles after C8MFall; nAS=0 forces MCKE=1.
- LT_W=2: nRESout released 1 LTick after entering RUN. With nIPL2=0 during ARB: nBR_IOB=1, AoutOE stays 0, FSM waits in ARB until nIPL2=1.
- C8M held high 4+ cycles in RUN: nPOR=0, FSM back to HOLD, nRESout=0, AoutOE=0, nBR_IOB=0 next cycle. RST mid-QoS: all outputs at their reset values next cycle.
